lc_trans_req_gate: RTL

//  Front-end stage directly upstream of the life cycle controller's transition logic.

---
 rtl/lc_trans_pkg.sv | 60 ++++++
 rtl/lc_trans_req_gate.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/lc_trans_pkg.sv
// Shared types for the life cycle transition request gate.
// Holds the decoded state encoding, the status codes and the legality helpers.
package lc_trans_pkg;

  typedef enum logic [2:0] {
    DecLcStRaw     = 3'd0,
    DecLcStTestUnl = 3'd1,
    DecLcStTestLck = 3'd2,
    DecLcStRma     = 3'd3,
    DecLcStInvalid = 3'd7
  } dec_lc_state_e;

  typedef enum logic [2:0] {
    TrStOk       = 3'd0,
    TrStIllegal  = 3'd1,
    TrStBadToken = 3'd2,
    TrStCoreFail = 3'd3,
    TrStTimeout  = 3'd4,
    TrStLocked   = 3'd5
  } lc_trans_status_e;

  typedef enum logic [2:0] {
    GIdle,
    GCheck,
    GIssue,
    GWaitAck,
    GResp,
    GLocked
  } gate_state_e;

  function automatic logic lc_trans_legal(
    input logic [2:0] src,
    input logic [2:0] dst
  );
    logic ok;
    ok = 1'b0;
    unique case (1'b1)
      src == DecLcStRaw:
        ok = (dst == DecLcStTestUnl);
      src == DecLcStTestUnl:
        ok = (dst == DecLcStTestLck) ||
             (dst == DecLcStRma);
      src == DecLcStTestLck:
        ok = (dst == DecLcStTestUnl) ||
             (dst == DecLcStRma);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic lc_trans_guarded(
    input logic [2:0] src,
    input logic [2:0] dst
  );
    return (dst == DecLcStRma) ||
           (src == DecLcStTestLck &&
            dst == DecLcStTestUnl);
  endfunction

endpackage

// File: rtl/lc_trans_req_gate.sv
// Checks host transition requests before they reach the life cycle controller.
// Counts failed attempts and locks out until reset once the threshold is hit.
module lc_trans_req_gate
  import lc_trans_pkg::*;
#(
  parameter int unsigned TOKEN_W      = 32,
  parameter logic [TOKEN_W-1:0] UNLOCK_TOKEN = 32'hC0DE_5A5A,
  parameter int unsigned MAX_FAILS    = 3,
  parameter int unsigned ACK_TIMEOUT  = 64,
  localparam int unsigned FCW = $clog2(MAX_FAILS + 1),
  localparam int unsigned TW  = $clog2(ACK_TIMEOUT + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [2:0]         req_target_i,
  input  logic [TOKEN_W-1:0] req_token_i,
  input  logic [2:0]         cur_state_i,
  output logic               trans_cmd_o,
  output logic [2:0]         trans_target_o,
  input  logic               trans_ack_i,
  input  logic               trans_ok_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [2:0]         rsp_status_o,
  output logic [FCW-1:0]     fail_cnt_o,
  output logic               locked_o
);

  localparam logic [FCW-1:0] FMAX = FCW'(MAX_FAILS);
  localparam logic [TW-1:0]  TLAST = TW'(ACK_TIMEOUT - 1);

  gate_state_e      state_q, state_d;
  lc_trans_status_e status_q, status_d;
  logic [2:0]         tgt_q, tgt_d;
  logic [2:0]         src_q, src_d;
  logic [TOKEN_W-1:0] tok_q, tok_d;
  logic               cmd_q, cmd_d;
  logic               rsp_q, rsp_d;
  logic [FCW-1:0]     fail_q, fail_d;
  logic               lock_q, lock_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic               fail_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= GIdle;
      status_q <= TrStOk;
      tgt_q    <= '0;
      src_q    <= '0;
      tok_q    <= '0;
      cmd_q    <= 1'b0;
      rsp_q    <= 1'b0;
      fail_q   <= '0;
      lock_q   <= 1'b0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      tgt_q    <= tgt_d;
      src_q    <= src_d;
      tok_q    <= tok_d;
      cmd_q    <= cmd_d;
      rsp_q    <= rsp_d;
      fail_q   <= fail_d;
      lock_q   <= lock_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    tgt_d    = tgt_q;
    src_d    = src_q;
    tok_d    = tok_q;
    cmd_d    = cmd_q;
    rsp_d    = rsp_q;
    fail_d   = fail_q;
    lock_d   = lock_q;
    tmo_d    = tmo_q;
    fail_evt = 1'b0;
    unique case (state_q)
      GIdle: begin
        if (req_valid_i) begin
          tgt_d   = req_target_i;
          tok_d   = req_token_i;
          src_d   = cur_state_i;
          state_d = GCheck;
        end
      end
      GCheck: begin
        if (!lc_trans_legal(src_q, tgt_q)) begin
          status_d = TrStIllegal;
          fail_evt = 1'b1;
        end else if (lc_trans_guarded(src_q, tgt_q) &&
                     tok_q != UNLOCK_TOKEN) begin
          status_d = TrStBadToken;
          fail_evt = 1'b1;
        end else begin
          state_d = GIssue;
        end
        if (fail_evt) begin
          rsp_d   = 1'b1;
          state_d = GResp;
        end
      end
      GIssue: begin
        cmd_d   = 1'b1;
        tmo_d   = '0;
        state_d = GWaitAck;
      end
      GWaitAck: begin
        tmo_d = tmo_q + 1'b1;
        // An ack landing on the last timeout cycle still counts.
        if (trans_ack_i) begin
          cmd_d    = 1'b0;
          rsp_d    = 1'b1;
          status_d = trans_ok_i ? TrStOk : TrStCoreFail;
          fail_evt = !trans_ok_i;
          state_d  = GResp;
        end else if (tmo_q == TLAST) begin
          cmd_d    = 1'b0;
          rsp_d    = 1'b1;
          status_d = TrStTimeout;
          fail_evt = 1'b1;
          state_d  = GResp;
        end
      end
      GResp: begin
        if (rsp_ready_i) begin
          rsp_d   = 1'b0;
          state_d = lock_q ? GLocked : GIdle;
        end
      end
      GLocked: begin
        if (req_valid_i) begin
          status_d = TrStLocked;
          rsp_d    = 1'b1;
          state_d  = GResp;
        end
      end
      default: state_d = GIdle;
    endcase
    if (fail_evt && fail_q != FMAX) begin
      fail_d = fail_q + 1'b1;
      if (fail_d == FMAX) lock_d = 1'b1;
    end
  end

  assign req_ready_o = rst_n &
    (state_q == GIdle || state_q == GLocked);
  assign trans_cmd_o    = cmd_q;
  assign trans_target_o = tgt_q;
  assign rsp_valid_o    = rsp_q;
  assign rsp_status_o   = status_q;
  assign fail_cnt_o     = fail_q;
  assign locked_o       = lock_q;

endmodule
